// File: rtl/alu_ctrl.sv
// alu_ctrl: 3-cycle instruction sequencer driving an external ALU over an 8x32 register file.
// Optional status flags are built only when ALU_CTRL_FLAGS_EN is defined.
module alu_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [2:0]        alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_dout,
  input  logic              alu_cout,
  output logic              done,
  output logic              err,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic              flag_c,
  output logic              flag_z
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_op;
  logic [2:0]        r_rd;
  logic [9:0]        r_imm;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_rf [8];

  logic              w_accept;
  logic              w_wr;
  logic [DATA_W-1:0] w_ra;
  logic [DATA_W-1:0] w_rb;
  logic [DATA_W-1:0] w_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (instr_valid) w_next = S_EXEC;
      S_EXEC:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign instr_ready = (r_state == S_IDLE) && !rst;
  assign w_accept    = instr_valid && instr_ready;

  // r0 is never written, but reads are gated so it is zero by construction
  assign w_ra = (instr[9:7] == 3'd0) ? '0 : r_rf[instr[9:7]];
  assign w_rb = (instr[6:4] == 3'd0) ? '0 : r_rf[instr[6:4]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op  <= '0;
      r_rd  <= '0;
      r_imm <= '0;
      r_a   <= '0;
      r_b   <= '0;
    end else if (w_accept) begin
      r_op  <= instr[15:13];
      r_rd  <= instr[12:10];
      r_imm <= instr[9:0];
      r_a   <= w_ra;
      r_b   <= w_rb;
    end
  end

  assign w_wr = (r_state == S_EXEC) && (r_op != OP_ILL)
             && (r_rd != 3'd0);
  assign w_wdata = (r_op == OP_LDI)
                 ? {{(DATA_W-10){1'b0}}, r_imm}
                 : alu_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else if (w_wr) begin
      r_rf[r_rd] <= w_wdata;
    end
  end

  assign alu_control = r_op;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign done        = (r_state == S_DONE);
  assign err         = done && (r_op == OP_ILL);
  assign dbg_data    = (dbg_sel == 3'd0) ? '0 : r_rf[dbg_sel];

`ifdef ALU_CTRL_FLAGS_EN
  logic r_flag_c;
  logic r_flag_z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
    end else if (r_state == S_EXEC) begin
      if (r_op == 3'b100 || r_op == 3'b101) r_flag_c <= alu_cout;
      if (r_op <= 3'b101) r_flag_z <= (alu_dout == '0);
    end
  end

  assign flag_c = r_flag_c;
  assign flag_z = r_flag_z;
`else
  logic w_unused_cout;
  assign w_unused_cout = alu_cout;
  assign flag_c = 1'b0;
  assign flag_z = 1'b0;
`endif

endmodule
